// File: rtl/affine_pkg.sv
// affine_pkg: shared types and defaults for the affine batch sequencer.
//   seq_state_t   sequencer FSM state
//   AFFINE_WIDTH  default signed coordinate width
//   AFFINE_DEPTH  default entries per point FIFO
package affine_pkg;

    localparam int unsigned AFFINE_WIDTH = 16;
    localparam int unsigned AFFINE_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/affine_batch_seq_if.sv
// affine_batch_seq_if: handshake bundle between the sequencer and its environment.
//   in_*   source points (valid/ready)
//   out_*  transformed points (valid/ready)
//   eng_*  start/done exchange with the external affine engine
// Modports: slave = sequencer side, master = environment side.
interface affine_batch_seq_if
    import affine_pkg::*;
#(
    parameter int unsigned WIDTH = AFFINE_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;

    logic             eng_start;
    logic [WIDTH-1:0] eng_x;
    logic [WIDTH-1:0] eng_y;
    logic             eng_done;
    logic [WIDTH-1:0] eng_rx;
    logic [WIDTH-1:0] eng_ry;

    modport slave (
        input  in_valid, in_x, in_y, out_ready, eng_done, eng_rx, eng_ry,
        output in_ready, out_valid, out_x, out_y, eng_start, eng_x, eng_y
    );

    modport master (
        output in_valid, in_x, in_y, out_ready, eng_done, eng_rx, eng_ry,
        input  in_ready, out_valid, out_x, out_y, eng_start, eng_x, eng_y
    );
endinterface

// File: rtl/point_fifo.sv
// point_fifo: synchronous FIFO of (x, y) point pairs.
//   clk, rst_n       clock, asynchronous active-low reset
//   clr_i            empty the FIFO; overrides a same-cycle push/pop
//   push_i, x_i/y_i  write request; refused while full, even with a same-cycle pop
//   pop_i            read request; ignored while empty
//   x_o, y_o         head entry
//   count_o          occupancy; full_o / empty_o derived from it
module point_fifo #(
    parameter int unsigned  WIDTH = 16,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_x_q [DEPTH];
    logic [WIDTH-1:0] mem_y_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = cnt_q;
    assign x_o     = mem_x_q[rd_q];
    assign y_o     = mem_y_q[rd_q];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + 1'b1;
            if (pop_ok)  rd_d = rd_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
            else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: nothing is read from it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) begin
            mem_x_q[wr_q] <= x_i;
            mem_y_q[wr_q] <= y_i;
        end
    end
endmodule

// File: rtl/affine_batch_seq.sv
// affine_batch_seq: buffers source points, issues them one at a time to an external affine
// engine and buffers the transformed results.
//   clk, rst_n     clock, asynchronous active-low reset
//   enable_i       allow new points to be issued to the engine
//   flush_i        empty both FIFOs, clear overflow, discard an in-flight result
//   bus (slave)    source-point, engine and result handshakes
//   in_count_o     input FIFO occupancy
//   out_count_o    output FIFO occupancy
//   batch_done_o   pulse after the last result of a batch has been buffered
//   overflow_o     sticky: a point was offered while the input FIFO was full
module affine_batch_seq
    import affine_pkg::*;
#(
    parameter int unsigned  WIDTH = AFFINE_WIDTH,
    parameter int unsigned  DEPTH = AFFINE_DEPTH,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              flush_i,
    affine_batch_seq_if.slave bus,
    output logic [CW-1:0]     in_count_o,
    output logic [CW-1:0]     out_count_o,
    output logic              batch_done_o,
    output logic              overflow_o
);
    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] eng_x_q, eng_x_d, eng_y_q, eng_y_d;
    logic             discard_q, discard_d;
    logic             batch_q, batch_d;
    logic             ovf_q, ovf_d;

    logic             in_full, in_empty, in_push, in_pop;
    logic             out_full, out_empty, out_push, out_pop;
    logic [WIDTH-1:0] in_head_x, in_head_y, out_head_x, out_head_y;
    logic             done_ok;

    assign in_push  = bus.in_valid && !in_full;
    assign in_pop   = (state_q == StIssue);
    assign done_ok  = (state_q == StWait) && bus.eng_done;
    assign out_push = done_ok && !discard_q && !flush_i;
    assign out_pop  = !out_empty && bus.out_ready;

    point_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush_i),
        .push_i  (in_push),
        .pop_i   (in_pop),
        .x_i     (bus.in_x),
        .y_i     (bus.in_y),
        .x_o     (in_head_x),
        .y_o     (in_head_y),
        .count_o (in_count_o),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    point_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush_i),
        .push_i  (out_push),
        .pop_i   (out_pop),
        .x_i     (bus.eng_rx),
        .y_i     (bus.eng_ry),
        .x_o     (out_head_x),
        .y_o     (out_head_y),
        .count_o (out_count_o),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

    always_comb begin
        state_d   = state_q;
        eng_x_d   = eng_x_q;
        eng_y_d   = eng_y_q;
        discard_d = discard_q;
        unique case (state_q)
            // Only one point is ever in flight, so a non-full output FIFO here
            // guarantees a slot for its result.
            StIdle: begin
                if (enable_i && !in_empty && !out_full && !flush_i) begin
                    state_d = StIssue;
                    eng_x_d = in_head_x;
                    eng_y_d = in_head_y;
                end
            end
            StIssue: state_d = StWait;
            StWait:  if (bus.eng_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // A flush while a point is outstanding marks its future result as stale.
        if (done_ok) discard_d = 1'b0;
        if (flush_i && (state_q != StIdle) && !done_ok) discard_d = 1'b1;
    end

    assign batch_d = out_push && in_empty && !in_push;
    assign ovf_d   = flush_i ? 1'b0 : (ovf_q || (bus.in_valid && in_full));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            eng_x_q   <= '0;
            eng_y_q   <= '0;
            discard_q <= 1'b0;
            batch_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            eng_x_q   <= eng_x_d;
            eng_y_q   <= eng_y_d;
            discard_q <= discard_d;
            batch_q   <= batch_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = !in_full;
    assign bus.out_valid = !out_empty;
    assign bus.out_x     = out_head_x;
    assign bus.out_y     = out_head_y;
    assign bus.eng_start = (state_q == StIssue);
    assign bus.eng_x     = eng_x_q;
    assign bus.eng_y     = eng_y_q;
    assign batch_done_o  = batch_q;
    assign overflow_o    = ovf_q;
endmodule

// File: doc/affine_batch_seq.md
AFFINE_BATCH_SEQ -- requirements
Module: affine_batch_seq

Interface
REQ-001 Parameter WIDTH, default 16: signed coordinate width.
REQ-002 Parameter DEPTH, default 4: entries per point FIFO; power of two, at least 2.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  allow issuing points to the engine.
REQ-006 flush  input  1  single-cycle pulse; empty both FIFOs and clear errors.
REQ-007 in_valid / in_ready  input / output  1 / 1  source-point handshake.
REQ-008 in_x, in_y  input  WIDTH each  source point.
REQ-009 eng_start  output  1  one-cycle start pulse to the affine engine.
REQ-010 eng_x, eng_y  output  WIDTH each  operands; held stable from eng_start until eng_done.
REQ-011 eng_done  input  1  one-cycle pulse; engine result is valid in that cycle.
REQ-012 eng_rx, eng_ry  input  WIDTH each  engine result.
REQ-013 out_valid / out_ready  output / input  1 / 1  transformed-point handshake.
REQ-014 out_x, out_y  output  WIDTH each  head of the output FIFO.
REQ-015 in_count, out_count  output  $clog2(DEPTH)+1 each  FIFO occupancy.
REQ-016 batch_done  output  1  one-cycle pulse when the batch completes.
REQ-017 overflow  output  1  sticky error flag.

Function
REQ-018 A transfer occurs on any cycle where valid and ready are both high.
- in_ready = input FIFO not full.
- out_valid = output FIFO not empty.
REQ-019 Simultaneous push and pop on either FIFO:
- Both occur in the same cycle; count is unchanged.
- On a full input FIFO, push is refused even if a pop occurs that cycle.
REQ-020 FSM states: IDLE, ISSUE, WAIT.
REQ-021 IDLE -> ISSUE when all of the following hold:
- enable = 1;
- input FIFO is non-empty;
- out_count < DEPTH, so output space is reserved.
REQ-022 ISSUE, exactly one cycle:
- eng_start = 1;
- eng_x/eng_y = input FIFO head, registered;
- pop the input FIFO;
- next state is WAIT.
REQ-023 WAIT -> IDLE on eng_done; eng_rx/eng_ry are pushed into the output FIFO in that cycle.
REQ-024 The output push never overflows: space is reserved at ISSUE, and the output FIFO has no other writer.
REQ-025 Latency: a point pushed into an empty input FIFO at edge k, with enable high, gives eng_start high in cycle k+1..k+2.
REQ-026 Latency: eng_done in cycle m gives out_valid high from edge m+1.
REQ-027 enable deasserted in WAIT: the in-flight point completes normally; no new ISSUE occurs.
REQ-028 flush, with priority over the same-cycle push and pop on both FIFOs:
- both FIFOs are cleared;
- overflow is cleared;
- the FSM is not aborted; a result arriving afterwards for a point issued before the flush is discarded via a pending-discard flag.
REQ-029 batch_done pulses in the cycle after a non-discarded output push when, in the push cycle, the input FIFO is empty and no in-push occurs.
REQ-030 overflow is set on in_valid=1 while the input FIFO is full; it is held until flush or reset.
REQ-031 eng_done outside WAIT is ignored.
REQ-032 FIFO pointers wrap modulo DEPTH.

Reset
REQ-033 On rst_n low, asynchronously:
- FSM = IDLE;
- both FIFOs empty, counts 0;
- eng_start, batch_done and overflow = 0, and the discard flag = 0;
- in_ready = 1, out_valid = 0;
- eng_x/eng_y = 0.
REQ-034 Reset during WAIT abandons the point; a later stray eng_done is ignored per REQ-031.

Structure
REQ-035 Package affine_pkg SHALL hold the state enum seq_state_t and the defaults AFFINE_WIDTH=16 and AFFINE_DEPTH=4.
REQ-036 Sub-module point_fifo:
- fields: WIDTH, DEPTH, paired x/y storage, count output;
- instantiated twice, once for input and once for output.

Verification
REQ-037 The bench engine model SHALL return (x+1, y+2) exactly 5 cycles after eng_start.
REQ-038 Single point: enable=1, push (0x0010, 0xFFF0) -> eng_start one cycle later, out (0x0011, 0xFFF2) valid 6 cycles after start, batch_done pulse.
REQ-039 Fill: out_ready=0, enable=1, push 10 points -> 4 results produced, 4 held in the input FIFO, in_ready=0, overflow=1, 2 refused pushes.
REQ-040 Backpressure release: from REQ-039, out_ready=1 -> results arrive in order (x+1, y+2), counts reach 0, a single batch_done pulse.
REQ-041 Flush in WAIT: flush during the 3rd wait cycle -> the result is discarded, out_count=0, overflow=0, no batch_done.
REQ-042 Simultaneous: input FIFO at 3 entries, push and ISSUE pop in the same cycle -> in_count stays 3.
REQ-043 Reset mid-WAIT, followed by the model's stray eng_done -> outputs stay at reset values.
